// File: rtl/room_pkg.sv
// Shared types and constants for the room-adventure move driver.
// Holds the move mask type, driver FSM states and the autopilot route.
package room_pkg;

    // Move mask, bit order {n,s,e,w}; bits may be combined.
    typedef logic [3:0] move_t;

    localparam move_t MV_N = 4'b1000;
    localparam move_t MV_S = 4'b0100;
    localparam move_t MV_E = 4'b0010;
    localparam move_t MV_W = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_HALT
    } drv_state_t;

    localparam int ROUTE_LEN = 5;
    localparam int IDX_W     = 3;

    // Element 0 is the first move of the route.
    localparam move_t [0:ROUTE_LEN-1] ROUTE =
        {MV_E, MV_S, MV_W, MV_E, MV_S | MV_E};

    // Route lookup; indices past the end return an empty move.
    function automatic move_t route_at(input logic [IDX_W-1:0] i);
        route_at = '0;
        for (int j = 0; j < ROUTE_LEN; j++) begin
            if (i == IDX_W'(j)) begin
                route_at = ROUTE[j];
            end
        end
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus debounce counter for one raw button.
// Ports: clk, reset (sync, active-high), i_raw (async), o_level (debounced).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Count consecutive disagreeing samples; any agreeing one restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/room_driver.sv
// Turns debounced buttons or the autopilot route into one-cycle move strobes.
// Ports: clk, reset, btn_n/s/e/w, auto, sw_in, win_in, d_in -> n,s,e,w,v,busy,done.
module room_driver
    import room_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    input  logic btn_s,
    input  logic btn_e,
    input  logic btn_w,
    input  logic auto,
    input  logic sw_in,
    input  logic win_in,
    input  logic d_in,
    output logic n,
    output logic s,
    output logic e,
    output logic w,
    output logic v,
    output logic busy,
    output logic done
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [3:0]       w_btn;
    logic [3:0]       w_lvl;
    logic [3:0]       w_rise;
    drv_state_t       r_state;
    drv_state_t       w_next;
    move_t            w_load;
    logic             w_clr;
    logic             w_idx_inc;
    logic [3:0]       r_lvl_q;
    move_t            r_pend;
    move_t            r_mv;
    logic [IDX_W-1:0] r_idx;
    logic [GW-1:0]    r_gap;
    logic             r_v;
    logic             r_busy;
    logic             r_done;

    assign w_btn = {btn_n, btn_s, btn_e, btn_w};

    for (genvar g = 0; g < 4; g++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (w_btn[g]),
            .o_level(w_lvl[g])
        );
    end

    assign w_rise = w_lvl & ~r_lvl_q;

    always_comb begin
        w_next    = r_state;
        w_load    = '0;
        w_clr     = 1'b0;
        w_idx_inc = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!auto && (r_pend != '0)) begin
                    w_next = ST_ISSUE;
                    w_load = r_pend;
                    w_clr  = 1'b1;
                end else if (auto && (r_idx < IDX_W'(ROUTE_LEN))) begin
                    w_next    = ST_ISSUE;
                    w_load    = route_at(r_idx);
                    w_idx_inc = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (r_gap <= GW'(1)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
        endcase
        // Game over wins over any move that would start this cycle.
        if (win_in || d_in) begin
            w_next    = ST_HALT;
            w_clr     = 1'b0;
            w_idx_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_lvl_q <= '0;
            r_pend  <= '0;
            r_mv    <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lvl_q <= w_lvl;
            // Autopilot discards button edges so manual resumes empty.
            if (auto) begin
                r_pend <= '0;
            end else begin
                r_pend <= (w_clr ? move_t'('0) : r_pend) | w_rise;
            end
            r_mv   <= (w_next == ST_ISSUE) ? w_load : move_t'('0);
            r_busy <= (w_next == ST_ISSUE) || (w_next == ST_GAP);
            r_done <= (w_next == ST_HALT);
            if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (r_state == ST_ISSUE) begin
                r_gap <= GW'(GAP_CYCLES);
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap - GW'(1);
            end
            r_v <= r_v | sw_in;
        end
    end

    assign n    = r_mv[3];
    assign s    = r_mv[2];
    assign e    = r_mv[1];
    assign w    = r_mv[0];
    assign v    = r_v;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_room_driver.sv
// Directed bench for room_driver (default parameters).
// Strobes are logged per clock edge and compared against hand-timed offsets.
module tb_room_driver;

    logic clk = 1'b0;
    logic reset;
    logic btn_n, btn_s, btn_e, btn_w;
    logic auto, sw_in, win_in, d_in;
    logic n, s, e, w, v, busy, done;

    room_driver #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_n),
        .btn_s (btn_s),
        .btn_e (btn_e),
        .btn_w (btn_w),
        .auto  (auto),
        .sw_in (sw_in),
        .win_in(win_in),
        .d_in  (d_in),
        .n     (n),
        .s     (s),
        .e     (e),
        .w     (w),
        .v     (v),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int q_cyc[$];
    int q_mv[$];
    always @(negedge clk) begin
        if ({n, s, e, w} != 4'b0000) begin
            q_cyc.push_back(cyc);
            q_mv.push_back(int'({n, s, e, w}));
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int nc);
        repeat (nc) @(posedge clk);
        #1;
    endtask

    task automatic clrq();
        q_cyc.delete();
        q_mv.delete();
    endtask

    function automatic int off(input int i, input int k);
        if (i < q_cyc.size()) return q_cyc[i] - k;
        return -1;
    endfunction

    function automatic int mv(input int i);
        if (i < q_mv.size()) return q_mv[i];
        return -1;
    endfunction

    int k;
    int exp_off[5] = '{0, 4, 8, 12, 16};
    int exp_mv[5]  = '{2, 4, 1, 2, 6};

    initial begin
        reset = 1'b1;
        {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
        {auto, sw_in, win_in, d_in} = 4'b0000;
        tick(3);
        chk("rst_out", {n, s, e, w, v, busy, done}, 0);
        reset = 1'b0;
        tick(2);
        chk("idle_out", {n, s, e, w, v, busy, done}, 0);

        // Manual press held: one e strobe 7 edges after first sample
        clrq();
        k = cyc + 1;
        btn_e = 1'b1;
        tick(20);
        btn_e = 1'b0;
        tick(12);
        chk("man_cnt", q_cyc.size(), 1);
        chk("man_lat", off(0, k), 7);
        chk("man_mv", mv(0), 4'b0010);

        // Bounce 1,0,1,0 then settle high at k+4
        clrq();
        k = cyc + 1;
        btn_n = 1'b1; tick(1);
        btn_n = 1'b0; tick(1);
        btn_n = 1'b1; tick(1);
        btn_n = 1'b0; tick(1);
        btn_n = 1'b1; tick(20);
        btn_n = 1'b0; tick(12);
        chk("bnc_cnt", q_cyc.size(), 1);
        chk("bnc_lat", off(0, k), 11);
        chk("bnc_mv", mv(0), 4'b1000);

        // s+e together, then w whose edge lands in GAP
        clrq();
        k = cyc + 1;
        btn_s = 1'b1;
        btn_e = 1'b1;
        tick(3);
        btn_w = 1'b1;
        tick(20);
        {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
        tick(12);
        chk("sim_cnt", q_cyc.size(), 2);
        chk("sim_lat", off(0, k), 7);
        chk("sim_mv", mv(0), 4'b0110);
        chk("gap_lat", off(1, k), 11);
        chk("gap_mv", mv(1), 4'b0001);

        // Autopilot route, button edge discarded, sword after 3rd move
        clrq();
        k = cyc + 1;
        auto = 1'b1;
        btn_n = 1'b1;
        tick(9);
        chk("auto_busy", busy, 1);
        chk("v_before", v, 0);
        sw_in = 1'b1;
        tick(1);
        chk("v_set", v, 1);
        sw_in = 1'b0;
        btn_n = 1'b0;
        tick(31);
        chk("v_sticky", v, 1);
        chk("auto_cnt", q_cyc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("auto_off%0d", i), off(i, k), exp_off[i]);
            chk($sformatf("auto_mv%0d", i), mv(i), exp_mv[i]);
        end
        clrq();
        auto = 1'b0;
        tick(20);
        chk("auto_discard", q_cyc.size(), 0);

        // Death in the cycle pending is nonzero: no strobe, then halt
        clrq();
        k = cyc + 1;
        btn_e = 1'b1;
        tick(7);
        chk("done_pre", done, 0);
        d_in = 1'b1;
        tick(1);
        chk("done_set", done, 1);
        chk("halt_busy", busy, 0);
        d_in = 1'b0;
        btn_e = 1'b0;
        tick(12);
        btn_w = 1'b1;
        tick(12);
        btn_w = 1'b0;
        tick(5);
        chk("halt_cnt", q_cyc.size(), 0);
        chk("halt_done", done, 1);
        chk("halt_v", v, 1);

        // Advance route by two moves, then reset mid-GAP with s pending
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        clrq();
        auto = 1'b1;
        tick(5);
        auto = 1'b0;
        tick(10);
        chk("pre_route_cnt", q_cyc.size(), 2);
        clrq();
        k = cyc + 1;
        btn_n = 1'b1;
        sw_in = 1'b1;
        tick(2);
        sw_in = 1'b0;
        btn_s = 1'b1;
        tick(7);
        chk("mid_busy", busy, 1);
        chk("mid_v", v, 1);
        reset = 1'b1;
        {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
        tick(1);
        chk("rst_mid", {n, s, e, w, v, busy, done}, 0);
        reset = 1'b0;
        tick(20);
        chk("rst_pend_cnt", q_cyc.size(), 1);
        chk("rst_pend_mv", mv(0), 4'b1000);
        clrq();
        k = cyc + 1;
        auto = 1'b1;
        tick(3);
        chk("rst_idx_lat", off(0, k), 0);
        chk("rst_idx_mv", mv(0), 4'b0010);
        auto = 1'b0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/room_driver.md
# room_driver

Move-command initiator for the room-adventure state machine: turns four raw direction buttons, or a built-in autopilot route, into single-cycle `n`/`s`/`e`/`w` move strobes for the room FSM. It also holds the sticky sword flag `v` from the room FSM's `sw` output. It stops issuing moves once the room FSM reports `win` or `d`. It sits between the board buttons and the room FSM's direction inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change; legal range is 1 or more.
- `GAP_CYCLES`, default 2: idle cycles forced after every strobe; 0 is legal.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `btn_n`, `btn_s`, `btn_e`, `btn_w` in 1 each: raw asynchronous buttons, active-high.
- `auto` in 1: 1 = autopilot route, 0 = manual buttons.
- `sw_in` in 1: sword-room indication from the room FSM.
- `win_in` in 1: win indication from the room FSM.
- `d_in` in 1: death indication from the room FSM.
- `n`, `s`, `e`, `w` out 1 each: registered move strobes to the room FSM.
- `v` out 1: registered sticky sword-held flag.
- `busy` out 1: 1 in ISSUE or GAP.
- `done` out 1: 1 in HALT.

## Operation
- Reset value of every output is 0. Reset also clears synchronizers, debounce counters, debounced levels, the pending mask, the route index and the gap counter. FSM resets to IDLE.
- **Input path, per button:**
  - 2-flop synchronizer.
  - Debouncer: counts consecutive cycles where the synchronized value differs from the debounced level. Reaching `DEBOUNCE_CYCLES` updates the level and zeroes the counter. Any agreeing sample zeroes the counter.
- **Pending mask, 4 bits:**
  - A rising edge of a debounced level sets the matching pending bit.
  - Falling edges do nothing.
  - While `auto`=1, the pending mask is held at 0 and edges are discarded.
- **FSM states:** IDLE, ISSUE, GAP, HALT.
  - IDLE, `auto`=0, pending≠0: load the whole pending mask into the move register, clear it, go to ISSUE. Simultaneous pending bits (for example S and E) issue together as one combined strobe. No priority is applied.
  - IDLE, `auto`=1, idx<`ROUTE_LEN`: load `ROUTE[idx]`, increment idx, go to ISSUE.
  - IDLE, `auto`=1, idx=`ROUTE_LEN`: stay in IDLE. There is no wrap; only reset restarts the route.
  - ISSUE: drive move-register bits on `n`/`s`/`e`/`w` for exactly one cycle. Load gap counter with `GAP_CYCLES`. Go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - GAP: decrement; when the count reaches 0, go to IDLE. Button edges arriving in ISSUE or GAP accumulate in the pending mask.
  - Any state, when `win_in` or `d_in` is sampled 1, goes to HALT next cycle. HALT beats a same-cycle ISSUE entry, so no strobe is issued.
  - HALT: strobes 0, pending ignored. Exit only via reset.
- Toggling `auto` mid-route keeps idx. Switching to manual resumes button handling from an empty pending mask.
- `v`: set the cycle after `sw_in` is sampled 1. Cleared only by reset. It stays set in HALT.

## Timing
- Button latency: raw high sampled at edge k gives:
  - synchronized high after edge k+1;
  - debounced high after edge k+1+`DEBOUNCE_CYCLES`;
  - pending set after edge k+2+`DEBOUNCE_CYCLES`;
  - strobe high for the one cycle after edge k+3+`DEBOUNCE_CYCLES`.
- Minimum strobe spacing is 1+`GAP_CYCLES` cycles of zero strobes between consecutive strobes.
- Autopilot: the first strobe is high the cycle after the first IDLE cycle with `auto`=1. Subsequent strobes are 2+`GAP_CYCLES` cycles apart.
- `win_in`/`d_in` to `done`: 1 cycle.
- `sw_in` to `v`: 1 cycle.
- All outputs come directly from flops.

## Structure
- Package `room_pkg` holds:
  - `move_t`: 4-bit one-hot/combinable mask, bit order {n,s,e,w};
  - `drv_state_t` enum;
  - `ROUTE_LEN`=5;
  - `ROUTE` constant = E, S, W, E, S|E.
- One sub-module `button_debounce` (synchronizer plus debounce counter, parameter `DEBOUNCE_CYCLES`), instantiated 4×. The counter width is $clog2(`DEBOUNCE_CYCLES`+1).

## Test plan
- Manual press: `DEBOUNCE_CYCLES`=4, `btn_e` high held → `e`=1 for exactly one cycle, 7 cycles after first sample; no other strobes while held.
- Bounce: `btn_n` toggles 1,0,1,0 on alternating cycles, then settles high → exactly one `n` strobe, timed from the settle point.
- Simultaneous: `btn_s`, `btn_e` rise same cycle → a single cycle with `s`=1 and `e`=1. A second press of `btn_w` during GAP (`GAP_CYCLES`=2) → `w` strobe after 3 zero cycles.
- Autopilot: `auto`=1 → strobes E, S, W, E, S|E spaced 4 cycles apart, then none. Assert `sw_in` after the third strobe → `v`=1 the next cycle, sticky.
- Halt: `d_in`=1 in the same cycle pending becomes nonzero → no strobe, `done`=1 next cycle, further presses ignored.
- Reset mid-GAP with pending set → all outputs 0 next cycle, pending cleared, idx 0.
